kd_tree_root_ctrl: RTL

- Host-side command initiator for the kd-tree node array. It drives the root node's top-facing command/data port and sequences tree bring-up in three phases: reset, center fill, sort-axis configuration.
- It buffers a batch of centers from a valid/ready host stream, then issues the node command protocol and waits for each phase's done response from the root.
- It reports busy, done and timeout error to the host.

---
 rtl/kd_tree_root_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/kd_tree_root_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kd_tree_root_ctrl
// Brief    : Host-side bring-up sequencer for the kd-tree root node.
//            It buffers a batch of centers, then runs three phases: reset,
//            center fill and sort-axis configuration.
// Revision : 1.0 - initial release
// ============================================================================
module kd_tree_root_ctrl #(
    parameter int DATA_W      = 24,
    parameter int CMD_W       = 5,
    parameter int MAX_CENTERS = 16,
    parameter int CNT_W       = $clog2(MAX_CENTERS + 1),
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_centers,
    input  logic [1:0]        axis,
    input  logic [DATA_W-1:0] center_in,
    input  logic              center_valid,
    output logic              center_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CMD_W-1:0]  cmd_to_root,
    output logic [DATA_W-1:0] data_to_root,
    input  logic [CMD_W-1:0]  cmd_from_root,
    input  logic [DATA_W-1:0] data_from_root
);

    localparam int IDX_W = (MAX_CENTERS > 1) ? $clog2(MAX_CENTERS) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CMD_W-1:0] c_cmd_nop       = CMD_W'(5'b00000);
    localparam logic [CMD_W-1:0] c_cmd_rst       = CMD_W'(5'b11111);
    localparam logic [CMD_W-1:0] c_cmd_rst_done  = CMD_W'(5'b11110);
    localparam logic [CMD_W-1:0] c_cmd_fill      = CMD_W'(5'b00001);
    localparam logic [CMD_W-1:0] c_cmd_axis      = CMD_W'(5'b00010);
    localparam logic [CMD_W-1:0] c_cmd_fill_done = CMD_W'(5'b00101);
    localparam logic [CMD_W-1:0] c_cmd_axis_done = CMD_W'(5'b00111);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load   = 3'd1;
    localparam logic [2:0] c_st_rst    = 3'd2;
    localparam logic [2:0] c_st_fill   = 3'd3;
    localparam logic [2:0] c_st_axis   = 3'd4;
    localparam logic [2:0] c_st_finish = 3'd5;

    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT - 1);

    logic [2:0]        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_num, w_num_nxt;
    logic [1:0]        r_axis, w_axis_nxt;
    logic [CNT_W-1:0]  r_wr_cnt, w_wr_cnt_nxt;
    logic [CNT_W-1:0]  r_rd_cnt, w_rd_cnt_nxt;
    logic [TMO_W-1:0]  r_tmo_cnt, w_tmo_cnt_nxt;
    logic              r_error, w_error_nxt;
    logic              r_center_ready, w_center_ready_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic [CMD_W-1:0]  r_cmd, w_cmd_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic [DATA_W-1:0] r_buf [MAX_CENTERS];
    logic              w_accept;
    logic              w_unused;

    // Root data path is not consumed by this controller.
    assign w_unused = ^data_from_root;

    assign w_accept = (r_state == c_st_load) && center_valid && r_center_ready;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= c_st_idle;
            r_num          <= '0;
            r_axis         <= '0;
            r_wr_cnt       <= '0;
            r_rd_cnt       <= '0;
            r_tmo_cnt      <= '0;
            r_error        <= 1'b0;
            r_center_ready <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_cmd          <= c_cmd_nop;
            r_data         <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_num          <= w_num_nxt;
            r_axis         <= w_axis_nxt;
            r_wr_cnt       <= w_wr_cnt_nxt;
            r_rd_cnt       <= w_rd_cnt_nxt;
            r_tmo_cnt      <= w_tmo_cnt_nxt;
            r_error        <= w_error_nxt;
            r_center_ready <= w_center_ready_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_cmd          <= w_cmd_nxt;
            r_data         <= w_data_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wr_cnt[IDX_W-1:0]] <= center_in;
        end
    end

    // Next-state logic; the expected response wins over a same-cycle timeout.
    always_comb begin
        w_state_nxt   = r_state;
        w_num_nxt     = r_num;
        w_axis_nxt    = r_axis;
        w_wr_cnt_nxt  = r_wr_cnt;
        w_rd_cnt_nxt  = r_rd_cnt;
        w_tmo_cnt_nxt = r_tmo_cnt;
        w_error_nxt   = r_error;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    if ((num_centers == '0) || (num_centers > CNT_W'(MAX_CENTERS))) begin
                        w_error_nxt = 1'b1;
                    end else begin
                        w_num_nxt    = num_centers;
                        w_axis_nxt   = axis;
                        w_error_nxt  = 1'b0;
                        w_wr_cnt_nxt = '0;
                        w_state_nxt  = c_st_load;
                    end
                end
            end
            c_st_load: begin
                if (w_accept) begin
                    w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
                    if (r_wr_cnt + CNT_W'(1) == r_num) begin
                        w_tmo_cnt_nxt = '0;
                        w_state_nxt   = c_st_rst;
                    end
                end
            end
            c_st_rst: begin
                if (cmd_from_root == c_cmd_rst_done) begin
                    w_rd_cnt_nxt  = '0;
                    w_tmo_cnt_nxt = '0;
                    w_state_nxt   = c_st_fill;
                end else if (r_tmo_cnt == c_tmo_last) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
                end
            end
            c_st_fill: begin
                if (cmd_from_root == c_cmd_fill_done) begin
                    w_tmo_cnt_nxt = '0;
                    w_state_nxt   = c_st_axis;
                end else if (r_tmo_cnt == c_tmo_last) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
                    if (r_rd_cnt != r_num - CNT_W'(1)) begin
                        w_rd_cnt_nxt = r_rd_cnt + CNT_W'(1);
                    end
                end
            end
            c_st_axis: begin
                if (cmd_from_root == c_cmd_axis_done) begin
                    w_state_nxt = c_st_finish;
                end else if (r_tmo_cnt == c_tmo_last) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
                end
            end
            c_st_finish: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        w_cmd_nxt          = c_cmd_nop;
        w_data_nxt         = '0;
        w_center_ready_nxt = (w_state_nxt == c_st_load);
        w_busy_nxt         = (w_state_nxt != c_st_idle);
        w_done_nxt         = (w_state_nxt == c_st_finish);
        case (w_state_nxt)
            c_st_rst: begin
                w_cmd_nxt = c_cmd_rst;
            end
            c_st_fill: begin
                w_cmd_nxt  = c_cmd_fill;
                w_data_nxt = r_buf[w_rd_cnt_nxt[IDX_W-1:0]];
            end
            c_st_axis: begin
                w_cmd_nxt  = c_cmd_axis;
                w_data_nxt = {{(DATA_W-2){1'b0}}, w_axis_nxt};
            end
            default: begin
                w_cmd_nxt = c_cmd_nop;
            end
        endcase
    end

    assign center_ready = r_center_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign cmd_to_root  = r_cmd;
    assign data_to_root = r_data;

endmodule
`default_nettype wire
